// File: rtl/hazard_controller_if.sv
// rtl/hazard_controller_if.sv - decode-side control bundle between the MIPS pipeline and its hazard controller
interface hazard_controller_if #(
  parameter int STALL_CNT_W = 16
);
  logic                   w_id_valid;
  logic [4:0]             w_rs_addr_5;
  logic [4:0]             w_rt_addr_5;
  logic                   w_rs_used;
  logic                   w_rt_used;
  logic [4:0]             w_dest_addr_5;
  logic                   w_dest_we;
  logic                   w_mem_op;
  logic                   w_write_op;
  logic                   w_muldiv_start;
  logic                   w_hilo_read;
  logic                   w_branch_taken;
  logic                   w_stall_if;
  logic                   w_stall_id;
  logic                   w_bubble_ex;
  logic                   w_flush_id;
  logic [1:0]             w_fwd_rs_2;
  logic [1:0]             w_fwd_rt_2;
  logic                   w_muldiv_busy;
  logic [1:0]             w_stall_cause_2;
  logic [STALL_CNT_W-1:0] w_stall_cnt;

  modport master (
    output w_id_valid, w_rs_addr_5, w_rt_addr_5, w_rs_used, w_rt_used,
           w_dest_addr_5, w_dest_we, w_mem_op, w_write_op, w_muldiv_start,
           w_hilo_read, w_branch_taken,
    input  w_stall_if, w_stall_id, w_bubble_ex, w_flush_id, w_fwd_rs_2,
           w_fwd_rt_2, w_muldiv_busy, w_stall_cause_2, w_stall_cnt
  );

  modport slave (
    input  w_id_valid, w_rs_addr_5, w_rt_addr_5, w_rs_used, w_rt_used,
           w_dest_addr_5, w_dest_we, w_mem_op, w_write_op, w_muldiv_start,
           w_hilo_read, w_branch_taken,
    output w_stall_if, w_stall_id, w_bubble_ex, w_flush_id, w_fwd_rs_2,
           w_fwd_rt_2, w_muldiv_busy, w_stall_cause_2, w_stall_cnt
  );
endinterface

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - stall, flush, bubble, forwarding and mult/div sequencing for the 5-stage MIPS pipeline
module hazard_controller #(
  parameter int MULDIV_CYCLES = 32,
  parameter int STALL_CNT_W   = 16
) (
  input logic                clock,
  input logic                reset_n,
  hazard_controller_if.slave hz
);

  localparam logic [5:0] MD_LOAD = 6'(MULDIV_CYCLES);

  // WB needs no entry: the register file writes before it reads, so nothing consults it
  logic                   ex_valid;
  logic                   ex_we;
  logic                   ex_load;
  logic [4:0]             ex_dest;
  logic                   mem_valid;
  logic                   mem_we;
  logic [4:0]             mem_dest;
  logic [5:0]             md_cnt;
  logic [1:0]             fwd_rs_q;
  logic [1:0]             fwd_rt_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  logic       rs_ex_hit, rt_ex_hit, rs_mem_hit, rt_mem_hit;
  logic       load_use, md_busy, md_stall, flush, stall, advance;
  logic [1:0] cause, fwd_rs_d, fwd_rt_d;

  function automatic logic src_hit(input logic used, input logic [4:0] addr,
                                   input logic valid, input logic we,
                                   input logic [4:0] dest);
    return used && (addr != 5'd0) && valid && we && (dest == addr);
  endfunction

  always_comb begin
    rs_ex_hit  = src_hit(hz.w_rs_used, hz.w_rs_addr_5, ex_valid, ex_we, ex_dest);
    rt_ex_hit  = src_hit(hz.w_rt_used, hz.w_rt_addr_5, ex_valid, ex_we, ex_dest);
    rs_mem_hit = src_hit(hz.w_rs_used, hz.w_rs_addr_5, mem_valid, mem_we, mem_dest);
    rt_mem_hit = src_hit(hz.w_rt_used, hz.w_rt_addr_5, mem_valid, mem_we, mem_dest);

    load_use = hz.w_id_valid & ex_load & (rs_ex_hit | rt_ex_hit);
    md_busy  = (md_cnt != 6'd0);
    md_stall = hz.w_id_valid & md_busy & (hz.w_hilo_read | hz.w_muldiv_start);
    flush    = hz.w_branch_taken;
    stall    = (load_use | md_stall) & ~flush;
    advance  = hz.w_id_valid & ~load_use & ~md_stall & ~flush;

    cause = 2'b00;
    if (flush)         cause = 2'b11;
    else if (load_use) cause = 2'b01;
    else if (md_stall) cause = 2'b10;

    // the younger producer (EX) wins when both EX and MEM write the same register
    fwd_rs_d = rs_ex_hit ? 2'b01 : (rs_mem_hit ? 2'b10 : 2'b00);
    fwd_rt_d = rt_ex_hit ? 2'b01 : (rt_mem_hit ? 2'b10 : 2'b00);
  end

  assign hz.w_stall_if      = stall;
  assign hz.w_stall_id      = stall;
  assign hz.w_bubble_ex     = stall | flush;
  assign hz.w_flush_id      = flush;
  assign hz.w_fwd_rs_2      = fwd_rs_q;
  assign hz.w_fwd_rt_2      = fwd_rt_q;
  assign hz.w_muldiv_busy   = md_busy;
  assign hz.w_stall_cause_2 = cause;
  assign hz.w_stall_cnt     = stall_cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid    <= 1'b0;
      ex_we       <= 1'b0;
      ex_load     <= 1'b0;
      ex_dest     <= 5'd0;
      mem_valid   <= 1'b0;
      mem_we      <= 1'b0;
      mem_dest    <= 5'd0;
      md_cnt      <= 6'd0;
      fwd_rs_q    <= 2'b00;
      fwd_rt_q    <= 2'b00;
      stall_cnt_q <= '0;
    end else begin
      mem_valid <= ex_valid;
      mem_we    <= ex_we;
      mem_dest  <= ex_dest;

      ex_valid <= advance;
      ex_we    <= advance & hz.w_dest_we;
      ex_dest  <= advance ? hz.w_dest_addr_5 : 5'd0;
      ex_load  <= advance & hz.w_mem_op & ~hz.w_write_op;
      fwd_rs_q <= advance ? fwd_rs_d : 2'b00;
      fwd_rt_q <= advance ? fwd_rt_d : 2'b00;

      // a start seen while the counter is idle is launched even if decode stalls for load-use
      if (md_busy)
        md_cnt <= md_cnt - 6'd1;
      else if (hz.w_muldiv_start & hz.w_id_valid & ~flush)
        md_cnt <= MD_LOAD;

      if ((cause != 2'b00) && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - randomized and directed self-checking bench for hazard_controller
module tb_hazard_controller;

  localparam int MD    = 4;
  localparam int CW    = 16;
  localparam int CMAX  = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  hazard_controller_if #(.STALL_CNT_W(CW)) hz();

  hazard_controller #(.MULDIV_CYCLES(MD), .STALL_CNT_W(CW)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .hz     (hz)
  );

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic       rs_used;
    logic       rt_used;
    logic       we;
    logic       mem;
    logic       wr;
    logic       mds;
    logic       hilo;
  } dec_t;

  // one in-flight instruction as the model sees it, with the operand sources it was issued with
  typedef struct {
    bit       valid;
    bit       we;
    bit       load;
    bit [4:0] dest;
    bit [1:0] frs;
    bit [1:0] frt;
  } slot_t;

  slot_t m_ex, m_mem;
  int    m_busy;
  int    m_stalls;
  int    checks = 0;
  int    fails  = 0;

  logic       s_stall_if, s_bubble, s_flush, s_busy;
  logic [1:0] s_fwd_rs, s_fwd_rt, s_cause;
  logic [CW-1:0] s_cnt;

  function automatic dec_t nop();
    dec_t d = '0;
    return d;
  endfunction

  function automatic dec_t alu(input int rd, input int rs, input int rt);
    dec_t d = '0;
    d.valid = 1; d.rs = 5'(rs); d.rt = 5'(rt); d.dest = 5'(rd);
    d.rs_used = 1; d.rt_used = 1; d.we = 1;
    return d;
  endfunction

  function automatic dec_t lw(input int rt, input int base);
    dec_t d = '0;
    d.valid = 1; d.rs = 5'(base); d.rt = 5'(rt); d.dest = 5'(rt);
    d.rs_used = 1; d.we = 1; d.mem = 1;
    return d;
  endfunction

  function automatic dec_t sw(input int rt, input int base);
    dec_t d = '0;
    d.valid = 1; d.rs = 5'(base); d.rt = 5'(rt);
    d.rs_used = 1; d.rt_used = 1; d.mem = 1; d.wr = 1;
    return d;
  endfunction

  function automatic dec_t mult(input int rs, input int rt);
    dec_t d = '0;
    d.valid = 1; d.rs = 5'(rs); d.rt = 5'(rt);
    d.rs_used = 1; d.rt_used = 1; d.mds = 1;
    return d;
  endfunction

  function automatic dec_t mflo(input int rd);
    dec_t d = '0;
    d.valid = 1; d.dest = 5'(rd); d.we = 1; d.hilo = 1;
    return d;
  endfunction

  function automatic bit produces(input slot_t s, input bit [4:0] r);
    return s.valid && s.we && (r != 5'd0) && (s.dest == r);
  endfunction

  function automatic bit [1:0] source(input bit used, input bit [4:0] r);
    if (!used) return 2'b00;
    if (produces(m_ex, r)) return 2'b01;
    if (produces(m_mem, r)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ex     = '{default: 0};
    m_mem    = '{default: 0};
    m_busy   = 0;
    m_stalls = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    hz.w_id_valid = 0; hz.w_rs_addr_5 = 0; hz.w_rt_addr_5 = 0; hz.w_rs_used = 0;
    hz.w_rt_used = 0; hz.w_dest_addr_5 = 0; hz.w_dest_we = 0; hz.w_mem_op = 0;
    hz.w_write_op = 0; hz.w_muldiv_start = 0; hz.w_hilo_read = 0; hz.w_branch_taken = 0;
    #1;
    chk("rst_stall_if", 32'(hz.w_stall_if), 0);
    chk("rst_bubble", 32'(hz.w_bubble_ex), 0);
    chk("rst_fwd_rs", 32'(hz.w_fwd_rs_2), 0);
    chk("rst_fwd_rt", 32'(hz.w_fwd_rt_2), 0);
    chk("rst_busy", 32'(hz.w_muldiv_busy), 0);
    chk("rst_cause", 32'(hz.w_stall_cause_2), 0);
    chk("rst_cnt", 32'(hz.w_stall_cnt), 0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // drive one decode slot at the falling edge, compare all outputs, then step the model across the next rising edge
  task automatic tick(input dec_t d, input bit br);
    bit       lu, md, e_stall;
    bit [1:0] e_cause;
    slot_t    nxt;
    hz.w_id_valid = d.valid; hz.w_rs_addr_5 = d.rs; hz.w_rt_addr_5 = d.rt;
    hz.w_rs_used = d.rs_used; hz.w_rt_used = d.rt_used; hz.w_dest_addr_5 = d.dest;
    hz.w_dest_we = d.we; hz.w_mem_op = d.mem; hz.w_write_op = d.wr;
    hz.w_muldiv_start = d.mds; hz.w_hilo_read = d.hilo; hz.w_branch_taken = br;
    #1;
    lu = d.valid && m_ex.load &&
         ((d.rs_used && produces(m_ex, d.rs)) || (d.rt_used && produces(m_ex, d.rt)));
    md = d.valid && (m_busy > 0) && (d.hilo || d.mds);
    e_stall = (lu || md) && !br;
    e_cause = br ? 2'b11 : lu ? 2'b01 : md ? 2'b10 : 2'b00;

    chk("stall_if", 32'(hz.w_stall_if), 32'(e_stall));
    chk("stall_id", 32'(hz.w_stall_id), 32'(e_stall));
    chk("bubble_ex", 32'(hz.w_bubble_ex), 32'(e_stall || br));
    chk("flush_id", 32'(hz.w_flush_id), 32'(br));
    chk("cause", 32'(hz.w_stall_cause_2), 32'(e_cause));
    chk("fwd_rs", 32'(hz.w_fwd_rs_2), 32'(m_ex.frs));
    chk("fwd_rt", 32'(hz.w_fwd_rt_2), 32'(m_ex.frt));
    chk("busy", 32'(hz.w_muldiv_busy), 32'(m_busy > 0));
    chk("stall_cnt", 32'(hz.w_stall_cnt), 32'(m_stalls));

    s_stall_if = hz.w_stall_if; s_bubble = hz.w_bubble_ex; s_flush = hz.w_flush_id;
    s_busy = hz.w_muldiv_busy; s_fwd_rs = hz.w_fwd_rs_2; s_fwd_rt = hz.w_fwd_rt_2;
    s_cause = hz.w_stall_cause_2; s_cnt = hz.w_stall_cnt;

    if (e_cause != 2'b00 && m_stalls < CMAX) m_stalls++;
    if (m_busy == 0) begin
      if (d.valid && d.mds && !br) m_busy = MD;
    end else begin
      m_busy--;
    end
    nxt = '{default: 0};
    if (d.valid && !lu && !md && !br) begin
      nxt.valid = 1;
      nxt.we    = d.we;
      nxt.load  = d.mem && !d.wr;
      nxt.dest  = d.dest;
      nxt.frs   = source(d.rs_used, d.rs);
      nxt.frt   = source(d.rt_used, d.rt);
    end
    m_mem = m_ex;
    m_ex  = nxt;
    @(negedge clock);
  endtask

  function automatic dec_t rand_dec();
    dec_t d;
    int   r0 = $urandom_range(0, 3);
    int   r1 = $urandom_range(0, 3);
    int   r2 = $urandom_range(0, 3);
    case ($urandom_range(0, 7))
      0, 1, 2, 3: d = alu(r0, r1, r2);
      4:          d = lw(r0, r1);
      5:          d = sw(r0, r1);
      6:          d = mult(r1, r2);
      default:    d = mflo(r0);
    endcase
    if ($urandom_range(0, 9) == 0) d.valid = 1'b0;
    return d;
  endfunction

  initial begin
    reset_n = 1'b1;
    #2;
    do_reset();

    // load-use: one stall cycle, then the consumer forwards from WB
    tick(lw(8, 9), 0);
    tick(alu(10, 8, 11), 0);
    chk("lu_stall_if", 32'(s_stall_if), 1);
    chk("lu_bubble", 32'(s_bubble), 1);
    chk("lu_cause", 32'(s_cause), 1);
    tick(alu(10, 8, 11), 0);
    chk("lu_resolved", 32'(s_cause), 0);
    tick(nop(), 0);
    chk("lu_fwd_rs", 32'(s_fwd_rs), 2);
    chk("lu_fwd_rt", 32'(s_fwd_rt), 0);

    // back-to-back ALU dependency, then with one instruction between
    tick(alu(8, 9, 10), 0);
    tick(alu(11, 8, 8), 0);
    chk("alu_nostall", 32'(s_stall_if), 0);
    tick(nop(), 0);
    chk("alu_fwd_rs_ex", 32'(s_fwd_rs), 1);
    chk("alu_fwd_rt_ex", 32'(s_fwd_rt), 1);
    tick(alu(8, 9, 10), 0);
    tick(alu(12, 13, 14), 0);
    tick(alu(11, 8, 8), 0);
    tick(nop(), 0);
    chk("alu_fwd_rs_mem", 32'(s_fwd_rs), 2);
    chk("alu_fwd_rt_mem", 32'(s_fwd_rt), 2);

    // register zero never hazards
    tick(alu(0, 9, 10), 0);
    tick(alu(11, 0, 0), 0);
    chk("r0_nostall", 32'(s_cause), 0);
    tick(nop(), 0);
    chk("r0_fwd_rs", 32'(s_fwd_rs), 0);
    chk("r0_fwd_rt", 32'(s_fwd_rt), 0);

    // MULT then MFLO: four stall cycles
    do_reset();
    tick(mult(8, 9), 0);
    for (int i = 0; i < MD; i++) begin
      tick(mflo(10), 0);
      chk("md_cause", 32'(s_cause), 2);
      chk("md_busy", 32'(s_busy), 1);
    end
    tick(mflo(10), 0);
    chk("md_done_cause", 32'(s_cause), 0);
    chk("md_done_busy", 32'(s_busy), 0);
    chk("md_stall_cnt", 32'(s_cnt), 4);

    // load-use coinciding with a taken branch: flush wins, dependent never reaches EX
    do_reset();
    tick(lw(8, 9), 0);
    tick(alu(10, 8, 11), 1);
    chk("fl_flush", 32'(s_flush), 1);
    chk("fl_bubble", 32'(s_bubble), 1);
    chk("fl_stall_if", 32'(s_stall_if), 0);
    chk("fl_cause", 32'(s_cause), 3);
    tick(alu(12, 10, 0), 0);
    tick(nop(), 0);
    chk("fl_no_dep_fwd", 32'(s_fwd_rs), 0);

    // reset in the middle of a mult/div with the counter at 2
    do_reset();
    tick(mult(1, 2), 0);
    tick(mflo(3), 0);
    tick(mflo(3), 0);
    chk("mid_cnt_before", 32'(s_cnt), 1);
    #2;
    do_reset();
    tick(nop(), 0);
    chk("mid_fwd_after", 32'(s_fwd_rs), 0);
    chk("mid_busy_after", 32'(s_busy), 0);

    // randomized traffic with occasional taken branches
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      tick(rand_dec(), ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
